// File: rtl/mem_xfer_pkg.sv
// Shared types and constants for the memory block-transfer engine.
//   state_t      : transfer FSM states
//   DIR_RD/DIR_WR: values of the dir request input
//   DEF_*        : default address, data and length widths
package mem_xfer_pkg;

  localparam int DEF_AW   = 16;
  localparam int DEF_DW   = 16;
  localparam int DEF_LENW = 8;

  localparam logic DIR_RD = 1'b0;  // memory -> rd stream
  localparam logic DIR_WR = 1'b1;  // wr stream -> memory

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DUMP,
    DONE
  } state_t;

endpackage

// File: rtl/mem_xfer_addr_cnt.sv
// Address pointer and remaining-word counter for one block transfer.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_ptr / load_cnt (start of a block)
//   step      : one word transferred; advance ptr, decrement cnt
//   ptr       : current word address, wraps modulo 2^AW
//   cnt       : words still to transfer
//   cnt_zero  : cnt == 0
module mem_xfer_addr_cnt #(
  parameter int AW   = 16,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [AW-1:0]   load_ptr,
  input  logic [LENW-1:0] load_cnt,
  input  logic            step,
  output logic [AW-1:0]   ptr,
  output logic [LENW-1:0] cnt,
  output logic            cnt_zero
);

  assign cnt_zero = (cnt == '0);

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (load) begin
      ptr <= load_ptr;
      cnt <= load_cnt;
    end else if (step && !cnt_zero) begin
      // Natural AW-bit overflow gives the all-ones -> 0 wrap.
      ptr <= ptr + 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mem_block_xfer.sv
// Initiator-side block-transfer engine for a single-cycle word memory
// (combinational read, write on posedge).
//   clk, rst            : clock, synchronous active-high reset
//   start/dir/base_addr/len/dump_en : block request, sampled in IDLE only
//   busy, done          : transfer in progress / one-cycle completion pulse
//   rd_valid/rd_data/rd_ready : registered read stream (dir = DIR_RD)
//   wr_valid/wr_data/wr_ready : write stream into memory (dir = DIR_WR)
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata : memory port
//   mem_dump            : one-cycle dump strobe after a write block
module mem_block_xfer
  import mem_xfer_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int LENW = DEF_LENW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dir,
  input  logic [AW-1:0]   base_addr,
  input  logic [LENW-1:0] len,
  input  logic            dump_en,
  output logic            busy,
  output logic            done,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  input  logic            rd_ready,
  input  logic            wr_valid,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_ready,
  output logic            mem_en,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_dump
);

  state_t          state;
  logic            dump_flag;
  logic            rd_fire;
  logic            wr_fire;
  logic            load;
  logic [AW-1:0]   ptr;
  logic [LENW-1:0] cnt;
  logic            cnt_zero;
  logic            cnt_last;

  assign load     = (state == IDLE) && start;
  assign cnt_last = (cnt == LENW'(1));

  mem_xfer_addr_cnt #(
    .AW   (AW),
    .LENW (LENW)
  ) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_ptr (base_addr),
    .load_cnt (len),
    .step     (rd_fire || wr_fire),
    .ptr      (ptr),
    .cnt      (cnt),
    .cnt_zero (cnt_zero)
  );

  // Memory strobes are combinational so a word moves every cycle. They are
  // gated by rst so an abort stops memory traffic in the reset cycle itself.
  // NOTE: every always_comb output gets a default first; without it the
  // states that do not assign a signal would infer a latch.
  always_comb begin
    rd_fire  = 1'b0;
    wr_fire  = 1'b0;
    wr_ready = 1'b0;
    if (!rst) begin
      case (state)
        RD: rd_fire = !cnt_zero && (!rd_valid || rd_ready);
        WR: begin
          wr_ready = !cnt_zero;
          wr_fire  = !cnt_zero && wr_valid;
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = rd_fire || wr_fire;
  assign mem_wr    = wr_fire;
  assign mem_addr  = ptr;
  assign mem_wdata = wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      mem_dump  <= 1'b0;
      dump_flag <= 1'b0;
    end else begin
      done     <= 1'b0;
      mem_dump <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dump_flag <= dump_en;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= (dir == DIR_WR) ? WR : RD;
              busy  <= 1'b1;
            end
          end
        end
        RD: begin
          if (rd_fire) begin
            rd_data  <= mem_rdata;
            rd_valid <= 1'b1;
          end else if (rd_ready) begin
            rd_valid <= 1'b0;
          end
          // All words fetched and the output buffer is empty or emptying on
          // this edge: the block is complete.
          if (cnt_zero && (!rd_valid || rd_ready)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        WR: begin
          if (wr_fire && cnt_last) begin
            if (dump_flag) begin
              state    <= DUMP;
              mem_dump <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        DUMP: begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_xfer.sv
module tb_mem_block_xfer;
  import mem_xfer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, dir, dump_en, rd_ready, wr_valid;
  logic [15:0] base_addr, wr_data, mem_rdata;
  logic [7:0]  len;
  logic        busy, done, rd_valid, wr_ready, mem_en, mem_wr, mem_dump;
  logic [15:0] rd_data, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_block_xfer #(.AW(16), .DW(16), .LENW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr),
    .len(len), .dump_en(dump_en), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_dump(mem_dump)
  );

  // Responder: single-cycle word memory.
  logic [15:0] mem   [0:65535];
  // Reference image of what memory must contain.
  logic [15:0] model [0:65535];
  int en_cnt   = 0;
  int dump_cnt = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_dump) dump_cnt <= dump_cnt + 1;
    if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [15:0] addr, input logic [15:0] val);
    mem[addr]   <= val;
    model[addr]  = val;
  endtask

  // One block transfer. mode: 0 = ready/valid always high, 1 = pattern
  // 1,0,0 repeating, 2 = random. restart pulses a conflicting start while
  // busy. rst_after >= 0 asserts rst once that many words were written.
  // wseed != 0 gives write data wseed*1, wseed*2, ...
  task automatic run_xfer(input logic d, input logic [15:0] b, input logic [7:0] l,
                          input logic de, input int mode, input bit restart,
                          input int rst_after, input logic [15:0] wseed);
    logic [15:0] q[$];
    logic [15:0] ptr, pv_data;
    logic        pv_valid, pv_ready, rdy_now, exp_busy, exp_wrdy;
    int cyc, exp_done, exp_dump, abort_cyc, writes, remaining, limit;
    int en0, dump0, extra, mm;
    bit finished;
    for (int i = 0; i < int'(l); i++) q.push_back(model[16'(int'(b) + i)]);
    ptr = b; remaining = int'(l); writes = 0; extra = 0; finished = 1'b0;
    exp_done = (l == 0) ? 1 : -1; exp_dump = -1; abort_cyc = -1;
    limit = 6 * int'(l) + 20;
    en0 = en_cnt; dump0 = dump_cnt;
    pv_valid = 1'b0; pv_ready = 1'b0; pv_data = '0;

    @(posedge clk); #1;
    start = 1'b1; dir = d; base_addr = b; len = l; dump_en = de;
    rd_ready = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    cyc = 0;
    while (1) begin
      cyc++;
      @(posedge clk); #1;
      start = restart && (cyc == 1);
      if (start) begin
        base_addr = b ^ 16'h4000;
        len       = l + 8'd3;
        dir       = ~d;
      end
      rst = (rst_after >= 0) && (abort_cyc < 0) && (writes == rst_after);
      if (rst) abort_cyc = cyc;
      case (mode)
        0:       rdy_now = 1'b1;
        1:       rdy_now = (cyc % 3 == 1);
        default: rdy_now = 1'($urandom_range(0, 1));
      endcase
      rd_ready = rdy_now;
      wr_valid = rdy_now;
      wr_data  = (wseed != 0) ? 16'(int'(wseed) * (writes + 1)) : 16'($urandom);
      @(negedge clk);

      check("dump_excl", mem_dump & mem_en, 0);
      if (abort_cyc >= 0 && cyc == abort_cyc) check("rst_cyc_en", mem_en, 0);
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        check("abort_flags", {busy, done, rd_valid, mem_en, mem_wr, mem_dump, wr_ready}, 0);
        check("abort_regs", {rd_data, mem_addr}, 0);
      end
      exp_busy = (l != 0) && !(exp_done >= 0 && cyc >= exp_done) &&
                 !(abort_cyc >= 0 && cyc > abort_cyc);
      check("busy", busy, exp_busy);
      check("done", done, (exp_done >= 0) && (cyc == exp_done));

      if (d == DIR_RD) begin
        check("rd_no_wr", mem_wr, 0);
        if (l != 0 && cyc == 1) begin
          check("rd_first_en", mem_en, 1);
          check("rd_lat1", rd_valid, 0);
        end
        if (mode == 0 && l != 0 && cyc == 2) check("rd_lat2", rd_valid, 1);
        if (pv_valid && !pv_ready) begin
          check("stall_valid", rd_valid, 1);
          check("stall_data", rd_data, pv_data);
        end
        if (rd_valid && !rd_ready) check("stall_en", mem_en, 0);
        if (rd_valid && rd_ready) begin
          if (q.size() == 0) extra++;
          else begin
            check("rd_data", rd_data, q.pop_front());
            if (q.size() == 0) exp_done = cyc + 1;
          end
        end
        pv_valid = rd_valid; pv_ready = rd_ready; pv_data = rd_data;
      end else begin
        exp_wrdy = (remaining > 0) && !(abort_cyc >= 0 && cyc >= abort_cyc);
        check("wr_ready", wr_ready, exp_wrdy);
        check("wr_en", mem_en, exp_wrdy && wr_valid);
        if (exp_wrdy && wr_valid) begin
          check("wr_strobe", mem_wr, 1);
          check("wr_addr", mem_addr, ptr);
          model[ptr] = wr_data;
          ptr++; remaining--; writes++;
          if (remaining == 0) begin
            if (de) begin exp_dump = cyc + 1; exp_done = cyc + 2; end
            else exp_done = cyc + 1;
          end
        end
      end
      check("dump", mem_dump, (exp_dump >= 0) && (cyc == exp_dump));

      if (exp_done >= 0 && cyc > exp_done) begin finished = 1'b1; break; end
      if (abort_cyc >= 0 && cyc > abort_cyc + 3) begin finished = 1'b1; break; end
      if (cyc >= limit) break;
    end
    rst = 1'b0; start = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;

    check("finished", finished, 1);
    if (d == DIR_RD) begin
      if (mode == 0 && l != 0) check("rd_done_cyc", exp_done, int'(l) + 2);
      check("rd_left", q.size(), 0);
      check("rd_extra", extra, 0);
      check("en_count", en_cnt - en0, int'(l));
    end else begin
      if (abort_cyc < 0) check("wr_left", remaining, 0);
      check("en_count", en_cnt - en0, writes);
    end
    check("dump_count", dump_cnt - dump0,
          (d == DIR_WR && de && abort_cyc < 0 && l != 0) ? 1 : 0);
    mm = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== model[i]) mm++;
    check("mem_image", mm, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir = DIR_RD; base_addr = '0; len = '0;
    dump_en = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 65536; i++) set_word(16'(i), 16'(i * 40503 + 7));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {busy, done, rd_valid, mem_en, mem_wr, mem_dump, wr_ready}, 0);
    check("reset_regs", {rd_data, mem_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed read of A0..A3 at 0x0010, consumer always ready.
    for (int i = 0; i < 4; i++) set_word(16'(16'h0010 + i), 16'(16'h00A0 + i));
    run_xfer(DIR_RD, 16'h0010, 8'd4, 1'b0, 0, 1'b0, -1, 16'h0);
    // Read with rd_ready toggling 1,0,0,...
    run_xfer(DIR_RD, 16'h0100, 8'd3, 1'b0, 1, 1'b0, -1, 16'h0);
    // Wrapping write with dump, then read it back.
    run_xfer(DIR_WR, 16'hFFFE, 8'd3, 1'b1, 0, 1'b0, -1, 16'h1111);
    check("wrap_fffe", mem[16'hFFFE], 16'h1111);
    check("wrap_ffff", mem[16'hFFFF], 16'h2222);
    check("wrap_0000", mem[16'h0000], 16'h3333);
    run_xfer(DIR_RD, 16'hFFFE, 8'd3, 1'b0, 0, 1'b0, -1, 16'h0);
    // Empty blocks.
    run_xfer(DIR_RD, 16'h0200, 8'd0, 1'b1, 0, 1'b0, -1, 16'h0);
    run_xfer(DIR_WR, 16'h0200, 8'd0, 1'b1, 0, 1'b0, -1, 16'h0);
    // start while busy must be ignored.
    run_xfer(DIR_RD, 16'h0300, 8'd5, 1'b0, 0, 1'b1, -1, 16'h0);
    run_xfer(DIR_WR, 16'h0400, 8'd4, 1'b0, 0, 1'b1, -1, 16'h0);
    // Reset after two of five writes.
    run_xfer(DIR_WR, 16'h0500, 8'd5, 1'b1, 0, 1'b0, 2, 16'h0);
    // Randomized blocks.
    for (int t = 0; t < 30; t++)
      run_xfer(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom_range(0, 24)),
               1'($urandom_range(0, 1)), 2, 1'b0, -1, 16'h0);
    // Long wrapping read with random back-pressure.
    run_xfer(DIR_RD, 16'hFFF0, 8'd40, 1'b0, 2, 1'b0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
